alu_seq8: RTL and testbench

8-bit operation sequencer that wraps the 4-bit combinational ALU. It accepts an 8-bit operation request and drives the ALU twice: low nibble first, then high nibble with the low-nibble carry chained in. It captures both partial results and reports an assembled 8-bit result with flags. The block sits directly around the ALU: it feeds the ALU's A/B/c_in/Op inputs and consumes its R/zero/carry/sign outputs.

---
 rtl/alu_seq8.sv | 154 +++++++++++++++
 tb/tb_alu_seq8.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq8.sv
// Sequences an 8-bit operation through a 4-bit combinational ALU, low nibble then high nibble.
// Optional back-to-back acceptance in DONE is enabled by defining ALU_SEQ8_B2B_EN.
module alu_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  input  logic [2:0] op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic [7:0] r,
  output logic       carry,
  output logic       zero,
  output logic       sign,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       accept;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       cin_reg;
  logic [2:0] op_reg;

  logic [3:0] lo_r_reg;
  logic       lo_c_reg;
  logic       lo_z_reg;

  logic [7:0] r_reg;
  logic       carry_reg;
  logic       zero_reg;
  logic       sign_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, request acceptance and the ALU operand mux for each nibble.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_cin    = 1'b0;
    alu_op     = 3'h0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        alu_a      = a_reg[3:0];
        alu_b      = b_reg[3:0];
        alu_cin    = cin_reg;
        alu_op     = op_reg;
        state_next = HIGH;
      end
      HIGH: begin
        alu_a      = a_reg[7:4];
        alu_b      = b_reg[7:4];
        alu_cin    = lo_c_reg;
        alu_op     = op_reg;
        state_next = DONE;
      end
      DONE: begin
`ifdef ALU_SEQ8_B2B_EN
        if (start) begin
          accept     = 1'b1;
          state_next = LOW;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches: later changes on a/b/c_in/op never reach the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      cin_reg <= 1'b0;
      op_reg  <= 3'h0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      cin_reg <= c_in;
      op_reg  <= op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_r_reg <= 4'h0;
      lo_c_reg <= 1'b0;
      lo_z_reg <= 1'b0;
    end else if (state_reg == LOW) begin
      lo_r_reg <= alu_r;
      lo_c_reg <= alu_carry;
      lo_z_reg <= alu_zero;
    end
  end

  // Published result changes only on the HIGH->DONE edge, so partials never show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg     <= 8'h00;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      sign_reg  <= 1'b0;
    end else if (state_reg == HIGH) begin
      r_reg     <= {alu_r, lo_r_reg};
      carry_reg <= alu_carry;
      zero_reg  <= alu_zero & lo_z_reg;
      sign_reg  <= alu_sign;
    end
  end

  assign r     = r_reg;
  assign carry = carry_reg;
  assign zero  = zero_reg;
  assign sign  = sign_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_alu_seq8.sv
// Directed self-checking bench for alu_seq8 with a small 4-bit ALU model in the loop.
// Expectations for the back-to-back case follow ALU_SEQ8_B2B_EN when it is defined.
module tb_alu_seq8;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic [2:0] op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [2:0] alu_op;
  logic [3:0] alu_r;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_sign;
  logic [7:0] r;
  logic       carry;
  logic       zero;
  logic       sign;
  logic       busy;
  logic       done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  alu_seq8 dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in), .op(op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .r(r), .carry(carry), .zero(zero), .sign(sign), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: op 000 adds with carry, any other op is a bitwise AND with carry 0.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
    if (alu_op == 3'b000) begin
      alu_r     = alu_sum[3:0];
      alu_carry = alu_sum[4];
    end else begin
      alu_r     = alu_a & alu_b;
      alu_carry = 1'b0;
    end
    alu_zero = (alu_r == 4'h0);
    alu_sign = alu_r[3];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with fixed-latency checks on the ALU drive and the published result.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tcin, input logic [2:0] top, input logic [7:0] exp_r,
                       input logic exp_c, input logic exp_z, input logic exp_s,
                       input logic exp_lo_c);
    a = ta; b = tb; c_in = tcin; op = top; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb; c_in = ~tcin;
    check_val({tag, ".low_busy"}, busy, 1);
    check_val({tag, ".low_done"}, done, 0);
    check_val({tag, ".low_alu_a"}, alu_a, ta[3:0]);
    check_val({tag, ".low_alu_b"}, alu_b, tb[3:0]);
    check_val({tag, ".low_alu_cin"}, alu_cin, tcin);
    check_val({tag, ".low_alu_op"}, alu_op, top);
    tick();
    check_val({tag, ".high_done"}, done, 0);
    check_val({tag, ".high_alu_a"}, alu_a, ta[7:4]);
    check_val({tag, ".high_alu_cin"}, alu_cin, exp_lo_c);
    tick();
    check_val({tag, ".done"}, done, 1);
    check_val({tag, ".r"}, r, exp_r);
    check_val({tag, ".carry"}, carry, exp_c);
    check_val({tag, ".zero"}, zero, exp_z);
    check_val({tag, ".sign"}, sign, exp_s);
    tick();
    check_val({tag, ".done_clr"}, done, 0);
    check_val({tag, ".busy_clr"}, busy, 0);
    $display("op %s: a=%02h b=%02h cin=%0d op=%0d -> r=%02h c=%0d z=%0d s=%0d",
             tag, ta, tb, tcin, top, r, carry, zero, sign);
  endtask

  int done1_cyc;
  int done2_cyc;
  logic [7:0] r1;
  logic [7:0] r2;
  int exp_gap;
  logic exp_busy3;

  initial begin
    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0; op = 3'b000;
    #1;
    check_val("rst.r", r, 0);
    check_val("rst.flags", {carry, zero, sign}, 0);
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.alu_a", alu_a, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    $display("reset: r=%02h busy=%0d done=%0d", r, busy, done);

    do_op("add3c15", 8'h3C, 8'h15, 1'b0, 3'b000, 8'h51, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("addff01", 8'hFF, 8'h01, 1'b0, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    do_op("add7f00", 8'h7F, 8'h00, 1'b1, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold.r", r, 8'h80);
      check_val("hold.flags", {carry, zero, sign}, 3'b001);
    end
    $display("hold: r=%02h after 10 idle cycles", r);
    do_op("andf03c", 8'hF0, 8'h3C, 1'b1, 3'b011, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high while operands change; only the first operands count.
    a = 8'h12; b = 8'h34; c_in = 1'b0; op = 3'b000; start = 1'b1;
    tick();
    a = 8'hAA; b = 8'h55;
    tick();
    a = 8'h0F; b = 8'hF0;
    check_val("held.alu_a", alu_a, 4'h1);
    check_val("held.alu_b", alu_b, 4'h3);
    start = 1'b0;
    tick();
    check_val("held.done", done, 1);
    check_val("held.r", r, 8'h46);
    tick();
    $display("held: r=%02h", r);

    // Reset in HIGH discards the operation and clears everything at once.
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_val("midrst.r", r, 0);
    check_val("midrst.flags", {carry, zero, sign}, 0);
    check_val("midrst.busy", busy, 0);
    check_val("midrst.done", done, 0);
    check_val("midrst.alu_a", alu_a, 0);
    tick();
    reset = 1'b0;
    tick();
    check_val("midrst.r_after", r, 0);
    $display("midrst: r=%02h busy=%0d", r, busy);
    do_op("add2143", 8'h21, 8'h43, 1'b0, 3'b000, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held across DONE with two requests.
`ifdef ALU_SEQ8_B2B_EN
    exp_gap = 3; exp_busy3 = 1'b1;
`else
    exp_gap = 4; exp_busy3 = 1'b0;
`endif
    done1_cyc = -1; done2_cyc = -1; r1 = 8'h00; r2 = 8'h00;
    a = 8'h01; b = 8'h01; c_in = 1'b0; op = 3'b000; start = 1'b1;
    tick();
    a = 8'h02; b = 8'h02;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 4) start = 1'b0;
      if (cyc == 3) check_val("b2b.busy3", busy, exp_busy3);
      if (done) begin
        if (done1_cyc < 0) begin
          done1_cyc = cyc; r1 = r;
        end else if (done2_cyc < 0) begin
          done2_cyc = cyc; r2 = r;
        end
      end
    end
    check_val("b2b.done1_cyc", done1_cyc, 2);
    check_val("b2b.gap", done2_cyc - done1_cyc, exp_gap);
    check_val("b2b.r1", r1, 8'h02);
    check_val("b2b.r2", r2, 8'h04);
    $display("b2b: done at %0d and %0d, r=%02h then %02h", done1_cyc, done2_cyc, r1, r2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
